// File: rtl/trigger_capture_pkg.sv
// trigger_pkg: shared types and constants for the trigger capture controller.
//   state_t      - capture FSM state encoding (3 bits, visible on sts_state)
//   ADDR_*       - register addresses, decoded on bus_waddr[1:0]
//   CTRL_*       - bit positions in the control register
//   EVT_*        - bit positions in the per-sample event field
package trigger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_READ = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_POST = 2'd1;

    localparam int CTRL_ARM = 0;
    localparam int CTRL_ABT = 1;

    localparam int EVT_TRG = 0;
    localparam int EVT_ABT = 1;

endpackage

// File: rtl/trigger_capture_if.sv
// trigger_capture_if: groups the three handshake paths of the capture block.
//   bus_*  - write-only configuration bus (wvalid/waddr/wdata, wready)
//   sti_*  - sample stream from the trigger stage (tvalid/tevent/tdata, tready)
//   sto_*  - readout stream to the host path (tvalid/tlast/tdata, tready)
// master = the environment side, slave = the capture block.
interface trigger_capture_if #(
    parameter int BAW = 6,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2
);
    logic           bus_wready;
    logic           bus_wvalid;
    logic [BAW-1:0] bus_waddr;
    logic [BDW-1:0] bus_wdata;

    logic           sti_tready;
    logic           sti_tvalid;
    logic [SEW-1:0] sti_tevent;
    logic [SDW-1:0] sti_tdata;

    logic           sto_tready;
    logic           sto_tvalid;
    logic           sto_tlast;
    logic [SDW-1:0] sto_tdata;

    modport master (
        input  bus_wready,
        output bus_wvalid, bus_waddr, bus_wdata,
        input  sti_tready,
        output sti_tvalid, sti_tevent, sti_tdata,
        output sto_tready,
        input  sto_tvalid, sto_tlast, sto_tdata
    );

    modport slave (
        output bus_wready,
        input  bus_wvalid, bus_waddr, bus_wdata,
        output sti_tready,
        input  sti_tvalid, sti_tevent, sti_tdata,
        input  sto_tready,
        output sto_tvalid, sto_tlast, sto_tdata
    );
endinterface

// File: rtl/trigger_capture_mem.sv
// trigger_capture_mem: simple dual-port sample RAM, DW x 2**AW.
//   clk            - clock
//   we/waddr/wdata - write port
//   re/raddr       - read request; rdata is valid the cycle after re
// The array has no reset; contents are undefined until written.
module trigger_capture_mem #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: ring-buffer capture of the trigger stage output, frozen a
// programmable number of samples after the trigger, then read out oldest first.
//   clk, rst        - clock, asynchronous active-high reset
//   io (slave)      - config bus, sample input stream, readout stream
//   sts_state       - current FSM state
//   sts_trg_adr     - buffer address of the trigger sample
//   sts_done        - one-cycle pulse after the final readout transfer
//
// state | meaning
// IDLE  | disarmed, input discarded
// FILL  | collecting D-post pre-trigger samples, trigger bits ignored
// WAIT  | ring running, waiting for a trigger sample
// POST  | storing the remaining post-trigger samples
// READ  | streaming the frozen buffer, input discarded
module trigger_capture
    import trigger_pkg::*;
#(
    parameter int BAW = 6,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int MAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    trigger_capture_if.slave io,
    output logic [2:0]     sts_state,
    output logic [MAW-1:0] sts_trg_adr,
    output logic           sts_done
);
    localparam int D = 2**MAW;
    localparam logic [MAW:0] D_V = (MAW+1)'(D);
    localparam logic [MAW:0] ONE = (MAW+1)'(1);

    state_t         state, next_state;
    logic [MAW:0]   cfg_post, post_sh, post_clamp, cnt, rd_cnt;
    logic [MAW-1:0] wr_ptr, rd_ptr;
    logic           mem_we, do_arm, do_trg, enter_read, rd_issue, pop;
    logic           rd_pend, rd_pend_last;
    logic [SDW-1:0] mem_rdata, fifo_d0, fifo_d1;
    logic           fifo_l0, fifo_l1;
    logic [1:0]     fifo_cnt;
    logic [2:0]     occ_next;
    logic           unused_bits;

    assign io.bus_wready = 1'b1;
    assign io.sti_tready = 1'b1;
    assign unused_bits   = ^{io.bus_waddr, io.bus_wdata};

    wire bus_ctrl = io.bus_wvalid && (io.bus_waddr[1:0] == ADDR_CTRL);
    wire arm_req  = bus_ctrl && io.bus_wdata[CTRL_ARM];
    wire bus_abt  = bus_ctrl && io.bus_wdata[CTRL_ABT];
    wire xfer     = io.sti_tvalid;
    wire evt_trg  = xfer && io.sti_tevent[EVT_TRG];
    wire cap_abt  = bus_abt || (xfer && io.sti_tevent[EVT_ABT]);

    always_comb begin
        post_clamp = cfg_post;
        if (cfg_post == '0)      post_clamp = ONE;
        else if (cfg_post > D_V) post_clamp = D_V;
    end

    trigger_capture_mem #(.DW(SDW), .AW(MAW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (io.sti_tdata),
        .re    (rd_issue),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    assign pop            = io.sto_tvalid && io.sto_tready;
    assign io.sto_tvalid  = (fifo_cnt != 2'd0);
    assign io.sto_tlast   = io.sto_tvalid && fifo_l0;
    assign io.sto_tdata   = fifo_d0;
    assign sts_state      = state;

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        do_arm     = 1'b0;
        do_trg     = 1'b0;
        case (state)
            ST_IDLE: if (arm_req && !bus_abt) begin
                do_arm     = 1'b1;
                next_state = (post_clamp == D_V) ? ST_WAIT : ST_FILL;
            end
            ST_FILL: if (cap_abt) next_state = ST_IDLE;
                     else if (xfer) begin
                         mem_we = 1'b1;
                         if (cnt == ONE) next_state = ST_WAIT;
                     end
            ST_WAIT: if (cap_abt) next_state = ST_IDLE;
                     else if (xfer) begin
                         mem_we = 1'b1;
                         if (evt_trg) begin
                             do_trg     = 1'b1;
                             next_state = (post_sh == ONE) ? ST_READ : ST_POST;
                         end
                     end
            ST_POST: if (cap_abt) next_state = ST_IDLE;
                     else if (xfer) begin
                         mem_we = 1'b1;
                         if (cnt == ONE) next_state = ST_READ;
                     end
            ST_READ: if (pop && fifo_l0) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    assign enter_read = (state != ST_READ) && (next_state == ST_READ);

    // Keep memory reads in flight plus buffered entries at most two, so the
    // output buffer never overflows while the host stalls.
    assign occ_next = 3'(fifo_cnt) + 3'(rd_pend) - 3'(pop);
    assign rd_issue = (state == ST_READ) && (rd_cnt != D_V) && (occ_next < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cfg_post     <= D_V;
            post_sh      <= D_V;
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_cnt       <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            sts_trg_adr  <= '0;
            sts_done     <= 1'b0;
        end else begin
            state    <= next_state;
            sts_done <= (state == ST_READ) && pop && fifo_l0;
            if (io.bus_wvalid && io.bus_waddr[1:0] == ADDR_POST)
                cfg_post <= io.bus_wdata[MAW:0];
            if (do_arm) post_sh <= post_clamp;

            // One down-counter serves both the fill length and the post count.
            if (do_arm)      cnt <= D_V - post_clamp;
            else if (do_trg) cnt <= post_sh - ONE;
            else if (mem_we) cnt <= cnt - ONE;

            if (do_arm)      wr_ptr <= '0;
            else if (mem_we) wr_ptr <= wr_ptr + MAW'(1);
            if (do_trg) sts_trg_adr <= wr_ptr;

            // The entering write still lands at wr_ptr, so the oldest sample
            // sits one past it.
            if (enter_read) begin
                rd_ptr <= wr_ptr + MAW'(1);
                rd_cnt <= '0;
            end else if (rd_issue) begin
                rd_ptr <= rd_ptr + MAW'(1);
                rd_cnt <= rd_cnt + ONE;
            end
            rd_pend      <= rd_issue;
            rd_pend_last <= rd_issue && (rd_cnt == D_V - ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt <= 2'd0;
            fifo_d0  <= '0;
            fifo_d1  <= '0;
            fifo_l0  <= 1'b0;
            fifo_l1  <= 1'b0;
        end else if (rd_pend && pop) begin
            if (fifo_cnt == 2'd2) begin
                fifo_d0 <= fifo_d1;
                fifo_l0 <= fifo_l1;
                fifo_d1 <= mem_rdata;
                fifo_l1 <= rd_pend_last;
            end else begin
                fifo_d0 <= mem_rdata;
                fifo_l0 <= rd_pend_last;
            end
        end else if (pop) begin
            fifo_d0  <= fifo_d1;
            fifo_l0  <= fifo_l1;
            fifo_cnt <= fifo_cnt - 2'd1;
        end else if (rd_pend) begin
            if (fifo_cnt == 2'd0) begin
                fifo_d0 <= mem_rdata;
                fifo_l0 <= rd_pend_last;
            end else begin
                fifo_d1 <= mem_rdata;
                fifo_l1 <= rd_pend_last;
            end
            fifo_cnt <= fifo_cnt + 2'd1;
        end
    end
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed bench for trigger_capture with D = 16.
// Samples carry their running index as data; expected readouts are the
// hand-derived index windows for each scenario.
module tb_trigger_capture;
    localparam int BAW = 6;
    localparam int BDW = 32;
    localparam int SDW = 32;
    localparam int SEW = 2;
    localparam int MAW = 4;

    logic           clk;
    logic           rst;
    logic [2:0]     sts_state;
    logic [MAW-1:0] sts_trg_adr;
    logic           sts_done;

    int vectors = 0;
    int miscompares = 0;

    trigger_capture_if #(.BAW(BAW), .BDW(BDW), .SDW(SDW), .SEW(SEW)) io ();

    trigger_capture #(.BAW(BAW), .BDW(BDW), .SDW(SDW), .SEW(SEW), .MAW(MAW)) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (io),
        .sts_state   (sts_state),
        .sts_trg_adr (sts_trg_adr),
        .sts_done    (sts_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        io.bus_wvalid = 1'b1;
        io.bus_waddr  = BAW'(addr);
        io.bus_wdata  = data;
        tick();
        io.bus_wvalid = 1'b0;
        io.bus_waddr  = '0;
        io.bus_wdata  = '0;
    endtask

    task automatic stream(input int n, input int trg_a, input int trg_b, input int abt);
        for (int i = 0; i < n; i++) begin
            io.sti_tvalid = 1'b1;
            io.sti_tdata  = SDW'(i);
            io.sti_tevent = {(i == abt), (i == trg_a || i == trg_b)};
            tick();
        end
        io.sti_tvalid = 1'b0;
        io.sti_tdata  = '0;
        io.sti_tevent = '0;
    endtask

    // Collect 16 readout samples starting at value first; ready is high with
    // probability pct percent. Checks order, tlast, stall stability, done.
    task automatic collect(input int first, input int pct);
        int got = 0;
        int cyc = 0;
        int dones = 0;
        logic stalled = 1'b0;
        logic [SDW-1:0] prev = '0;
        logic rdy;
        while (got < 16 && cyc < 400) begin
            rdy = ($urandom_range(0, 99) < pct);
            io.sto_tready = rdy;
            if (stalled)
                chk("stall_hold", 64'({io.sto_tvalid, io.sto_tdata}), 64'({1'b1, prev}));
            if (io.sto_tvalid) begin
                if (rdy) begin
                    chk("rd_data", 64'(io.sto_tdata), 64'(first + got));
                    chk("rd_last", 64'(io.sto_tlast), 64'(got == 15));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev = io.sto_tdata;
                end
            end
            tick();
            cyc++;
            if (sts_done) dones++;
        end
        io.sto_tready = 1'b0;
        chk("rd_count", 64'(got), 64'(16));
        for (int k = 0; k < 3; k++) begin
            tick();
            if (sts_done) dones++;
        end
        chk("done_pulses", 64'(dones), 64'(1));
        chk("idle_after_rd", 64'({sts_state, io.sto_tvalid}), 64'({3'd0, 1'b0}));
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        io.bus_wvalid = 1'b0;
        io.bus_waddr  = '0;
        io.bus_wdata  = '0;
        io.sti_tvalid = 1'b0;
        io.sti_tevent = '0;
        io.sti_tdata  = '0;
        io.sto_tready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_state",   64'(sts_state), 64'(0));
        chk("rst_tvalid",  64'(io.sto_tvalid), 64'(0));
        chk("rst_tlast",   64'(io.sto_tlast), 64'(0));
        chk("rst_tdata",   64'(io.sto_tdata), 64'(0));
        chk("rst_trg_adr", 64'(sts_trg_adr), 64'(0));
        chk("rst_done",    64'(sts_done), 64'(0));
        chk("wready",      64'(io.bus_wready), 64'(1));
        chk("tready",      64'(io.sti_tready), 64'(1));

        // Basic: post=4, trigger on 20 -> 8..23
        wr(2'd1, 32'd4);
        wr(2'd0, 32'd1);
        chk("basic_fill", 64'(sts_state), 64'(1));
        stream(40, 20, -1, -1);
        chk("basic_read", 64'(sts_state), 64'(4));
        chk("basic_trg_adr", 64'(sts_trg_adr), 64'(4));
        collect(8, 100);

        // Early trigger during FILL ignored -> 2..17
        wr(2'd0, 32'd1);
        stream(25, 3, 14, -1);
        chk("early_trg_adr", 64'(sts_trg_adr), 64'(14));
        collect(2, 100);

        // post=0 clamps to 1: readout ends with trigger sample -> 5..20
        wr(2'd1, 32'd0);
        wr(2'd0, 32'd1);
        stream(25, 20, -1, -1);
        chk("p0_trg_adr", 64'(sts_trg_adr), 64'(4));
        collect(5, 100);

        // post=16: WAIT right after arm, trigger on sample 0 -> 0..15
        wr(2'd1, 32'd16);
        wr(2'd0, 32'd1);
        chk("p16_wait", 64'(sts_state), 64'(2));
        stream(20, 0, -1, -1);
        chk("p16_trg_adr", 64'(sts_trg_adr), 64'(0));
        collect(0, 100);

        // Event 2'b11 in WAIT: abort wins, no readout
        wr(2'd1, 32'd4);
        wr(2'd0, 32'd1);
        stream(31, 20, -1, 20);
        chk("evt_abt_idle", 64'(sts_state), 64'(0));
        seen = 0;
        io.sto_tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (io.sto_tvalid) seen++;
            tick();
        end
        io.sto_tready = 1'b0;
        chk("evt_abt_novalid", 64'(seen), 64'(0));

        // Bus abort and arm+abort during READ are ignored
        wr(2'd0, 32'd1);
        stream(26, 20, -1, -1);
        chk("babt_read0", 64'(sts_state), 64'(4));
        wr(2'd0, 32'd2);
        chk("babt_read1", 64'(sts_state), 64'(4));
        wr(2'd0, 32'd3);
        chk("babt_read2", 64'(sts_state), 64'(4));
        collect(8, 100);

        // Backpressure: ready 30%
        wr(2'd0, 32'd1);
        stream(26, 20, -1, -1);
        collect(8, 30);

        // Reset on third post sample
        wr(2'd0, 32'd1);
        stream(22, 20, -1, -1);
        chk("rpost_state", 64'(sts_state), 64'(3));
        io.sti_tvalid = 1'b1;
        io.sti_tdata  = SDW'(22);
        rst = 1'b1;
        #2;
        chk("rpost_state0",  64'(sts_state), 64'(0));
        chk("rpost_trg_adr", 64'(sts_trg_adr), 64'(0));
        chk("rpost_outs",    64'({io.sto_tvalid, io.sto_tlast, sts_done}), 64'(0));
        chk("rpost_tdata",   64'(io.sto_tdata), 64'(0));
        io.sti_tvalid = 1'b0;
        io.sti_tdata  = '0;
        tick();
        rst = 1'b0;
        tick();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'd1);
        stream(40, 20, -1, -1);
        chk("rearm_trg_adr", 64'(sts_trg_adr), 64'(4));
        collect(8, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
